// File: rtl/load_store_unit.sv
// load_store_unit: single-request byte/half/word load-store engine in front of a word-wide memory
// with read-modify-write for sub-word stores and misalignment rejection.
module load_store_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Request,
  output logic                  Ready,
  input  logic                  Write,
  input  logic [1:0]            Size,
  input  logic                  Signed,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           StoreData,
  output logic                  Done,
  output logic [31:0]           LoadData,
  output logic                  Misaligned,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [31:0]           MemDataOut,
  output logic                  MemEnableWrite,
  input  logic [31:0]           MemDataIn
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, next;
  logic wr_q, sgn_q, mis_q, accept, bad;
  logic [1:0] size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0] wdata_q, load_q, shifted, ext, mask, merged;
  assign accept = Request && state == IDLE;
  assign bad = Size == 2'b11 || (CHECK_ALIGN && ((Size == 2'b01 && Address[0]) || (Size == 2'b10 && Address[1:0] != 2'b00)));
  always_comb begin
    next = state == IDLE  ? (accept ? (bad ? RESP : (Write && Size == 2'b10) ? WRITE : READ) : IDLE) :
           state == READ  ? (wr_q ? WRITE : RESP) :
           state == WRITE ? RESP : IDLE;
  end
  // Half lanes use only A[1], so with CHECK_ALIGN=0 the ignored low bits fall out naturally.
  always_comb begin
    shifted = size_q == 2'b00 ? MemDataIn >> {addr_q[1:0], 3'b000} :
              size_q == 2'b01 ? MemDataIn >> {addr_q[1], 4'b0000} : MemDataIn;
    ext     = size_q == 2'b00 ? {{24{sgn_q & shifted[7]}}, shifted[7:0]} :
              size_q == 2'b01 ? {{16{sgn_q & shifted[15]}}, shifted[15:0]} : shifted;
    mask    = size_q == 2'b00 ? 32'h0000_00FF << {addr_q[1:0], 3'b000} : 32'h0000_FFFF << {addr_q[1], 4'b0000};
    merged  = (MemDataIn & ~mask) | ((size_q == 2'b00 ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}}) & mask);
  end
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        wr_q    <= Write;
        size_q  <= Size;
        sgn_q   <= Signed;
        addr_q  <= Address;
        wdata_q <= StoreData;
      end
      if (state == READ && wr_q) wdata_q <= merged;
      if (next == RESP) begin
        load_q <= (state == READ && !wr_q) ? ext : 32'h0;
        mis_q  <= state == IDLE;
      end
    end
  end
  assign Ready          = state == IDLE;
  assign Done           = state == RESP;
  assign MemEnableWrite = state == WRITE;
  assign MemAddress     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign MemDataOut     = wdata_q;
  assign LoadData       = load_q;
  assign Misaligned     = mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized requests against a byte-array memory model, with per-cycle
// checks of handshake, latency, write pulses and results.
module tb_load_store_unit;
  logic Clock = 1'b0, ResetN = 1'b0, Request = 1'b0, Write = 1'b0, Signed = 1'b0;
  logic [1:0] Size = 2'b00;
  logic [31:0] Address = '0, StoreData = '0;
  logic Ready, Done, Misaligned, MemEnableWrite;
  logic [31:0] LoadData, MemAddress, MemDataOut, MemDataIn;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int tests = 0, fails = 0;
  int exp_lat = 0, exp_wcyc = 0, exp_nw = 0;
  logic [31:0] exp_load = '0, exp_waddr = '0, exp_wdata = '0;
  logic exp_mis = 1'b0;

  load_store_unit dut (
    .Clock(Clock), .ResetN(ResetN), .Request(Request), .Ready(Ready), .Write(Write),
    .Size(Size), .Signed(Signed), .Address(Address), .StoreData(StoreData), .Done(Done),
    .LoadData(LoadData), .Misaligned(Misaligned), .MemAddress(MemAddress),
    .MemDataOut(MemDataOut), .MemEnableWrite(MemEnableWrite), .MemDataIn(MemDataIn)
  );

  always #5 Clock = ~Clock;
  assign MemDataIn = mem[MemAddress[7:2]];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = i;
    forever begin
      @(posedge Clock);
      if (MemEnableWrite) mem[MemAddress[7:2]] <= MemDataOut;
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz, input logic sg, input logic [7:0] a);
    logic [7:0] b [4];
    int v;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      v = b[a[1:0]];
      if (sg && v >= 128) v -= 256;
    end else begin
      v = b[{a[1], 1'b0}] + 256 * b[{a[1], 1'b1}];
      if (sg && v >= 32768) v -= 65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
    logic [7:0] b [4];
    if (sz == 2'd2) return d;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    if (sz == 2'd0) b[a[1:0]] = d[7:0];
    else begin
      b[{a[1], 1'b0}] = d[7:0];
      b[{a[1], 1'b1}] = d[15:8];
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Monitor: tracks acceptance from the protocol rules and checks every cycle.
  initial begin
    int cnt, nw;
    bit pending;
    logic [31:0] last_load;
    logic last_mis;
    cnt = 0; nw = 0; pending = 0; last_load = '0; last_mis = 1'b0;
    forever begin
      @(negedge Clock);
      if (!ResetN) begin
        pending = 0; last_load = '0; last_mis = 1'b0;
        chk("rst_we", 32'(MemEnableWrite), 0);
        chk("rst_ready", 32'(Ready), 1);
        chk("rst_done", 32'(Done), 0);
        chk("rst_load", LoadData, 0);
        chk("rst_mis", 32'(Misaligned), 0);
        chk("rst_maddr", MemAddress, 0);
        chk("rst_mdout", MemDataOut, 0);
      end else begin
        if (pending) cnt++;
        chk("ready", 32'(Ready), 32'(!pending));
        if (MemEnableWrite) begin
          nw++;
          chk("we_cycle", pending ? cnt : -1, exp_wcyc);
          chk("we_addr", MemAddress, exp_waddr);
          chk("we_data", MemDataOut, exp_wdata);
        end
        if (Done) begin
          chk("done_pending", 32'(pending), 1);
          chk("latency", cnt, exp_lat);
          chk("load", LoadData, exp_load);
          chk("mis", 32'(Misaligned), 32'(exp_mis));
          chk("writes", nw, exp_nw);
          last_load = exp_load; last_mis = exp_mis;
          pending = 0;
        end else if (pending && cnt > 6) begin
          chk("timeout", 32'(Done), 1);
          pending = 0;
        end else if (!pending) begin
          chk("hold_load", LoadData, last_load);
          chk("hold_mis", 32'(Misaligned), 32'(last_mis));
          if (Request) begin pending = 1; cnt = 0; nw = 0; end
        end
      end
    end
  end

  task automatic req(input bit wr, input logic [1:0] sz, input bit sg, input logic [7:0] a,
                     input logic [31:0] sd, input bit hold, input bit abort, input bit pin, input logic [31:0] pv);
    bit bad;
    bad = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    exp_mis   = bad;
    exp_lat   = bad ? 1 : (wr && sz != 2'd2) ? 3 : 2;
    exp_nw    = (wr && !bad) ? 1 : 0;
    exp_wcyc  = sz == 2'd2 ? 1 : 2;
    exp_load  = (wr || bad) ? 32'h0 : model_load(ref_mem[a[7:2]], sz, sg, a);
    exp_waddr = {24'h0, a[7:2], 2'b00};
    exp_wdata = model_store(ref_mem[a[7:2]], sz, a, sd);
    if (pin) chk("model_pin", exp_load, pv);
    @(posedge Clock); #1;
    Request = 1'b1; Write = wr; Size = sz; Signed = sg; Address = {24'h0, a}; StoreData = sd;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      if (Ready) break;
    end
    @(posedge Clock); #1;
    if (!hold) Request = 1'b0;
    if (abort) begin
      @(posedge Clock); #2;
      ResetN = 1'b0; Request = 1'b0;
      repeat (2) @(posedge Clock);
      #1 ResetN = 1'b1;
      return;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      if (Done) break;
    end
    @(posedge Clock); #1;
    Request = 1'b0;
    if (wr && !bad) ref_mem[a[7:2]] = exp_wdata;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = i;
    repeat (3) @(posedge Clock);
    #1 ResetN = 1'b1;
    req(0, 2'd2, 0, 8'h14, 0, 0, 0, 1, 32'h0000_0005);
    req(1, 2'd0, 0, 8'h09, 32'h80, 0, 0, 0, 0);
    req(0, 2'd2, 0, 8'h08, 0, 0, 0, 1, 32'h0000_8002);
    req(0, 2'd0, 1, 8'h09, 0, 0, 0, 1, 32'hFFFF_FF80);
    req(0, 2'd0, 0, 8'h09, 0, 0, 0, 1, 32'h0000_0080);
    req(1, 2'd1, 0, 8'h0E, 32'hBEEF, 0, 0, 0, 0);
    chk("mem_word3", mem[3], 32'hBEEF_0003);
    req(0, 2'd1, 1, 8'h0E, 0, 0, 0, 1, 32'hFFFF_BEEF);
    req(0, 2'd2, 0, 8'h06, 0, 0, 0, 1, 32'h0);
    req(0, 2'd3, 0, 8'h04, 0, 0, 0, 1, 32'h0);
    req(1, 2'd0, 0, 8'h10, 32'h55, 0, 1, 0, 0);
    chk("mem_word4", mem[4], 32'h0000_0004);
    req(0, 2'd2, 0, 8'h10, 0, 0, 0, 1, 32'h0000_0004);
    req(1, 2'd2, 0, 8'h20, 32'h1234_5678, 1, 0, 0, 0);
    req(0, 2'd2, 0, 8'h20, 0, 0, 0, 1, 32'h1234_5678);
    req(1, 2'd0, 0, 8'h23, 32'hA5, 1, 0, 0, 0);
    req(0, 2'd0, 1, 8'h23, 0, 0, 0, 1, 32'hFFFF_FFA5);
    for (int n = 0; n < 400; n++) begin
      logic [7:0] a;
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 3));
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) a = sz == 2'd1 ? {a[7:1], 1'b0} : sz == 2'd2 ? {a[7:2], 2'b00} : a;
      req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), 0, 0, 0);
      repeat ($urandom_range(0, 2)) @(posedge Clock);
    end
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
